// File: rtl/inv_5xp1_seq_if.sv
// Handshake bundle for the 5xp1 inverse: code word in, recovered operand and
// error classification out.
interface inv_5xp1_seq_if #(
  parameter int YW = 10,
  parameter int XW = 7,
  parameter int RW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [YW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_x;
  logic [RW-1:0] out_rem;
  logic          out_err;
  logic [1:0]    out_code;

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_x, out_rem, out_err, out_code
  );

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_x, out_rem, out_err, out_code
  );
endinterface

// File: rtl/inv_5xp1_seq.sv
// Inverse of y = MULT*x + OFFS by serial restoring division, one quotient bit
// per cycle, with a single operation in flight and a legality classification.
module inv_5xp1_seq #(
  parameter  int YW   = 10,
  parameter  int XW   = 7,
  parameter  int MULT = 5,
  parameter  int OFFS = 1,
  localparam int RW   = $clog2(MULT),
  localparam int CW   = $clog2(YW)
) (
  input logic              clk,
  input logic              rst,
  inv_5xp1_seq_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [RW:0]   MULT_CMP = (RW+1)'(MULT);
  localparam logic [RW-1:0] MULT_SUB = RW'(MULT);

  state_t        state_q, state_d;
  logic [YW-1:0] d_q, d_d;
  logic          unf_q, unf_d;
  logic [RW-1:0] r_q, r_d;
  // The top quotient bit is only ever needed on the final step, so it is
  // never stored.
  logic [YW-2:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [RW-1:0] out_rem_q, out_rem_d;
  logic          out_err_q, out_err_d;
  logic [1:0]    out_code_q, out_code_d;

  logic [YW:0]   d_full;
  logic [RW:0]   r_shift;
  logic [RW-1:0] r_new;
  logic [YW-1:0] q_new;
  logic          ge;
  logic          ovf;
  logic [1:0]    code;
  logic          in_ready_c;
  logic          out_valid_c;

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    unf_d      = unf_q;
    r_d        = r_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    out_x_d    = out_x_q;
    out_rem_d  = out_rem_q;
    out_err_d  = out_err_q;
    out_code_d = out_code_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    // Sign bit of the widened subtraction doubles as the underflow flag.
    d_full  = {1'b0, bus.in_y} - (YW+1)'(OFFS);

    r_shift = {r_q, d_q[cnt_q]};
    ge      = (r_shift >= MULT_CMP);
    r_new   = ge ? (r_shift[RW-1:0] - MULT_SUB) : r_shift[RW-1:0];
    q_new   = {q_q, ge};
    ovf     = |q_new[YW-1:XW];

    if (unf_q)
      code = 2'd1;
    else if (ovf)
      code = 2'd3;
    else if (r_new != '0)
      code = 2'd2;
    else
      code = 2'd0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          d_d     = d_full[YW-1:0];
          unf_d   = d_full[YW];
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CW'(YW-1);
          state_d = CALC;
        end
      end
      CALC: begin
        r_d = r_new;
        q_d = q_new[YW-2:0];
        if (cnt_q == '0) begin
          out_x_d    = q_new[XW-1:0];
          out_rem_d  = r_new;
          out_code_d = code;
          out_err_d  = (code != 2'd0);
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      d_q        <= '0;
      unf_q      <= 1'b0;
      r_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      out_x_q    <= '0;
      out_rem_q  <= '0;
      out_err_q  <= 1'b0;
      out_code_q <= '0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      unf_q      <= unf_d;
      r_q        <= r_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      out_x_q    <= out_x_d;
      out_rem_q  <= out_rem_d;
      out_err_q  <= out_err_d;
      out_code_q <= out_code_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_x     = out_x_q;
  assign bus.out_rem   = out_rem_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_code  = out_code_q;

endmodule

// File: tb/tb_inv_5xp1_seq.sv
// Self-checking bench for inv_5xp1_seq: directed cases, backpressure, reset
// abort and an exhaustive sweep against an arithmetic reference model.
module tb_inv_5xp1_seq;
  localparam int YW   = 10;
  localparam int XW   = 7;
  localparam int MULT = 5;
  localparam int OFFS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  inv_5xp1_seq_if bus ();

  inv_5xp1_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // x, rem are meaningless for underflow and are returned as -1.
  function automatic void ref_model(input int y, output int x, output int rem, output int code);
    int q;
    if (y < OFFS) begin
      x = -1; rem = -1; code = 1;
    end else begin
      q    = (y - OFFS) / MULT;
      rem  = (y - OFFS) % MULT;
      x    = q % (1 << XW);
      code = (q > (1 << XW) - 1) ? 3 : ((rem != 0) ? 2 : 0);
    end
  endfunction

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic send(input int y, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_y     = y[YW-1:0];
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_y     = YW'($urandom);
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_x !== '0 ||
        bus.out_rem !== '0 || bus.out_err !== 1'b0 || bus.out_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b x=%0d rem=%0d err=%0b code=%0d, want rdy=1 vld=0 rest 0",
               bus.in_ready, bus.out_valid, bus.out_x, bus.out_rem, bus.out_err, bus.out_code);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_legal();
    int ys[3] = '{1, 36, 636};
    int x, rem, code, lat;
    bit ok, vok;
    foreach (ys[i]) begin
      ref_model(ys[i], x, rem, code);
      send(ys[i], ok);
      wait_valid(lat, vok);
      // Accepted at edge 0; out_valid is visible after edge YW (11th cycle).
      checks++;
      if (!ok || !vok || lat !== YW) begin
        errors++;
        $display("FAIL legal_latency y=%0d: got accept=%0b valid=%0b lat=%0d, want lat=%0d", ys[i], ok, vok, lat, YW);
      end
      checks++;
      if (bus.out_x !== XW'(x) || bus.out_rem !== 3'(rem)) begin
        errors++;
        $display("FAIL legal_value y=%0d: got x=%0d rem=%0d, want x=%0d rem=%0d", ys[i], bus.out_x, bus.out_rem, x, rem);
      end
      checks++;
      if (bus.out_code !== 2'(code) || bus.out_err !== 1'b0) begin
        errors++;
        $display("FAIL legal_code y=%0d: got code=%0d err=%0b, want code=%0d err=0", ys[i], bus.out_code, bus.out_err, code);
      end
      $display("legal y=%0d -> x=%0d rem=%0d code=%0d", ys[i], bus.out_x, bus.out_rem, bus.out_code);
      take();
    end
  endtask

  task automatic test_illegal();
    int ys[4] = '{0, 37, 641, 1023};
    int x, rem, code, lat;
    bit ok, vok;
    foreach (ys[i]) begin
      ref_model(ys[i], x, rem, code);
      send(ys[i], ok);
      wait_valid(lat, vok);
      checks++;
      if (!ok || !vok || bus.out_code !== 2'(code) || bus.out_err !== 1'b1) begin
        errors++;
        $display("FAIL illegal_code y=%0d: got valid=%0b code=%0d err=%0b, want code=%0d err=1",
                 ys[i], vok, bus.out_code, bus.out_err, code);
      end
      if (code != 1) begin
        checks++;
        if (bus.out_x !== XW'(x) || bus.out_rem !== 3'(rem)) begin
          errors++;
          $display("FAIL illegal_value y=%0d: got x=%0d rem=%0d, want x=%0d rem=%0d", ys[i], bus.out_x, bus.out_rem, x, rem);
        end
      end
      $display("illegal y=%0d -> x=%0d rem=%0d code=%0d err=%0b", ys[i], bus.out_x, bus.out_rem, bus.out_code, bus.out_err);
      take();
    end
  endtask

  task automatic test_backpressure();
    int y, x, rem, code, lat, bad;
    bit ok, vok;
    logic [XW-1:0] sx;
    logic [2:0]    sr;
    logic [1:0]    sc;
    logic          se;
    y = MULT * $urandom_range(0, 127) + OFFS;
    ref_model(y, x, rem, code);
    send(y, ok);
    wait_valid(lat, vok);
    sx = bus.out_x; sr = bus.out_rem; sc = bus.out_code; se = bus.out_err;
    checks++;
    if (!vok || sx !== XW'(x) || sc !== 2'(code)) begin
      errors++;
      $display("FAIL bp_result y=%0d: got x=%0d code=%0d, want x=%0d code=%0d", y, sx, sc, x, code);
    end
    bus.in_valid = 1'b1;
    bus.in_y     = YW'(6);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_x !== sx ||
          bus.out_rem !== sr || bus.out_code !== sc || bus.out_err !== se)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles, want 0", bad);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_x !== sx || bus.out_code !== sc) begin
      errors++;
      $display("FAIL bp_release: got rdy=%0b vld=%0b x=%0d code=%0d, want rdy=1 vld=0 x=%0d code=%0d",
               bus.in_ready, bus.out_valid, bus.out_x, bus.out_code, sx, sc);
    end
    send(6, ok);
    wait_valid(lat, vok);
    checks++;
    if (!ok || !vok || bus.out_x !== XW'(1) || bus.out_code !== 2'd0) begin
      errors++;
      $display("FAIL bp_followup: got x=%0d code=%0d, want x=1 code=0", bus.out_x, bus.out_code);
    end
    $display("backpressure y=%0d held 20 cycles, then y=6 -> x=%0d", y, bus.out_x);
    take();
  endtask

  task automatic test_back_to_back();
    int words[3] = '{11, 16, 21};
    int res_x[$];
    int res_cyc[$];
    int idx, x, rem, code;
    bit acc;
    idx = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_y      = YW'(words[0]);
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = bus.in_ready && bus.in_valid;
      if (bus.out_valid) begin
        res_x.push_back(int'(bus.out_x));
        res_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) bus.in_y = YW'(words[idx]);
        else bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b0;
    checks++;
    if (res_x.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want 3", res_x.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ref_model(words[i], x, rem, code);
        checks++;
        if (res_x[i] != x) begin
          errors++;
          $display("FAIL b2b_value[%0d]: got x=%0d, want x=%0d", i, res_x[i], x);
        end
        if (i > 0) begin
          checks++;
          if (res_cyc[i] - res_cyc[i-1] != YW + 2) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", i, res_cyc[i] - res_cyc[i-1], YW + 2);
          end
        end
        $display("b2b word=%0d -> x=%0d at cycle %0d", words[i], res_x[i], res_cyc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bad;
    bit ok, vok;
    send(101, ok);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_x !== '0 ||
        bus.out_rem !== '0 || bus.out_err !== 1'b0 || bus.out_code !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_async: got rdy=%0b vld=%0b x=%0d rem=%0d err=%0b code=%0d, want rdy=1 vld=0 rest 0",
               bus.in_ready, bus.out_valid, bus.out_x, bus.out_rem, bus.out_err, bus.out_code);
    end
    #6 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_novalid: got %0d cycles with out_valid, want 0", bad);
    end
    send(101, ok);
    wait_valid(lat, vok);
    checks++;
    if (!ok || !vok || bus.out_x !== XW'(20) || bus.out_code !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_retry: got x=%0d code=%0d, want x=20 code=0", bus.out_x, bus.out_code);
    end
    $display("reset mid-op then y=101 -> x=%0d", bus.out_x);
    take();
  endtask

  task automatic test_exhaustive();
    int x, rem, code, lat, nerr;
    bit ok, vok;
    nerr = 0;
    for (int y = 0; y < (1 << YW); y++) begin
      ref_model(y, x, rem, code);
      send(y, ok);
      wait_valid(lat, vok);
      checks++;
      if (!ok || !vok) begin
        errors++;
        $display("FAIL exh_timeout y=%0d: got accept=%0b valid=%0b, want both 1", y, ok, vok);
        continue;
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      checks++;
      if (bus.out_code !== 2'(code) || bus.out_err !== (code != 0) ||
          (code != 1 && (bus.out_x !== XW'(x) || bus.out_rem !== 3'(rem)))) begin
        errors++;
        nerr++;
        $display("FAIL exh_value y=%0d: got x=%0d rem=%0d code=%0d err=%0b, want x=%0d rem=%0d code=%0d",
                 y, bus.out_x, bus.out_rem, bus.out_code, bus.out_err, x, rem, code);
      end
      take();
    end
    $display("exhaustive sweep of %0d words done, %0d value errors", 1 << YW, nerr);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_legal();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
